// File: rtl/multiplier_pkg.sv
// Shared constants and the controller state encoding for the Booth multiplier.
package multiplier_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      BIST
   } state_e;

endpackage

// File: rtl/booth_core.sv
// Radix-2 Booth datapath: A/Q/Q[-1]/M registers and one add/sub-then-shift step per enabled clock.
// step_result is the A:Q value this step will produce, so the controller can capture it on the final edge.
module booth_core
   import multiplier_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_i,
   input  logic           step_i,
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic [2*N-1:0] step_result_o
);

   // A and M carry one extra sign bit so that -2^(N-1) * -2^(N-1) does not overflow.
   logic [N:0]   a_q, a_d, m_q, a_cur, sum;
   logic [N-1:0] q_q, q_d;
   logic         qm1_q, qm1_d;
   logic         a_lsb;

   assign a_lsb = a_q[0];
   assign a_cur = {a_q[N:1], a_lsb};

   always_comb begin
      case ({q_q[0], qm1_q})
         2'b10:   sum = a_cur - m_q;
         2'b01:   sum = a_cur + m_q;
         default: sum = a_cur;
      endcase
   end

   // Arithmetic shift of A:Q:Q[-1] one place to the right.
   assign a_d           = {sum[N], sum[N:1]};
   assign q_d           = {sum[0], q_q[N-1:1]};
   assign qm1_d         = q_q[0];
   assign step_result_o = {a_d[N-1:0], q_d};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         m_q   <= '0;
         q_q   <= '0;
         qm1_q <= 1'b0;
      end else if (load_i) begin
         a_q   <= '0;
         m_q   <= {a_i[N-1], a_i};
         q_q   <= b_i;
         qm1_q <= 1'b0;
      end else if (step_i) begin
         a_q   <= a_d;
         q_q   <= q_d;
         qm1_q <= qm1_d;
      end
   end

endmodule

// File: rtl/multiplier.sv
// Signed Booth multiplier with a BIST mode that sweeps every operand pair through the same datapath
// and compares each result against a combinational reference product.
module multiplier
   import multiplier_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           start,
   input  logic           test,
   output logic [2*N-1:0] product,
   output logic           busy,
   output logic           pass
);

   localparam int            CW        = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*N-1:0]   vec_q, vec_d;
   logic [2*N-1:0]   product_q, product_d;
   logic             load_ph_q, load_ph_d;
   logic             mismatch_q, mismatch_d;
   logic             busy_q, busy_d;
   logic             pass_q, pass_d;

   logic             core_load, core_step;
   logic [N-1:0]     core_a, core_b;
   logic [2*N-1:0]   step_result;
   logic [2*N-1:0]   ref_a, ref_b, ref_prod;

   booth_core #(.N(N)) u_core (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_i        (core_load),
      .step_i        (core_step),
      .a_i           (core_a),
      .b_i           (core_b),
      .step_result_o (step_result)
   );

   // Reference operands are sign-extended to 2N so the truncated product is the exact signed result.
   assign ref_a    = {{N{vec_q[2*N-1]}}, vec_q[2*N-1:N]};
   assign ref_b    = {{N{vec_q[N-1]}}, vec_q[N-1:0]};
   assign ref_prod = ref_a * ref_b;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      vec_d      = vec_q;
      product_d  = product_q;
      load_ph_d  = load_ph_q;
      mismatch_d = mismatch_q;
      busy_d     = busy_q;
      pass_d     = pass_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      core_a     = a;
      core_b     = b;

      case (state_q)
         IDLE: begin
            if (test) begin
               state_d    = BIST;
               busy_d     = 1'b1;
               mismatch_d = 1'b0;
               pass_d     = 1'b0;
               vec_d      = '0;
               load_ph_d  = 1'b1;
               cnt_d      = '0;
            end else if (start) begin
               state_d   = MUL;
               busy_d    = 1'b1;
               core_load = 1'b1;
               cnt_d     = '0;
            end
         end

         MUL: begin
            core_step = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) begin
               product_d = step_result;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end
         end

         BIST: begin
            core_a = vec_q[2*N-1:N];
            core_b = vec_q[N-1:0];
            if (load_ph_q) begin
               core_load = 1'b1;
               load_ph_d = 1'b0;
               cnt_d     = '0;
            end else begin
               core_step = 1'b1;
               cnt_d     = cnt_q + CW'(1);
               if (cnt_q == LAST_STEP) begin
                  product_d  = step_result;
                  load_ph_d  = 1'b1;
                  mismatch_d = mismatch_q | (step_result != ref_prod);
                  if (vec_q == '1) begin
                     pass_d  = ~mismatch_d;
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     vec_d = vec_q + (2*N)'(1);
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         vec_q      <= '0;
         product_q  <= '0;
         load_ph_q  <= 1'b0;
         mismatch_q <= 1'b0;
         busy_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         vec_q      <= vec_d;
         product_q  <= product_d;
         load_ph_q  <= load_ph_d;
         mismatch_q <= mismatch_d;
         busy_q     <= busy_d;
         pass_q     <= pass_d;
      end
   end

   assign product = product_q;
   assign busy    = busy_q;
   assign pass    = pass_q;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the Booth multiplier: expected products are queued when an operation is
// launched and popped when busy falls; busy length, pass and reset behaviour are checked inline.
module tb_multiplier;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   a = '0;
   logic [N-1:0]   b = '0;
   logic           start = 1'b0;
   logic           test = 1'b0;
   logic [2*N-1:0] product;
   logic           busy;
   logic           pass;

   int             checks = 0;
   int             errors = 0;
   logic [2*N-1:0] exp_q[$];
   logic [2*N-1:0] last_exp;

   always #5 clk = ~clk;

   multiplier #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .b       (b),
      .start   (start),
      .test    (test),
      .product (product),
      .busy    (busy),
      .pass    (pass)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_mul(input logic signed [N-1:0] x, input logic signed [N-1:0] y);
      int px;
      int py;
      px = x;
      py = y;
      exp_q.push_back((2*N)'(px * py));
   endtask

   // Called on the negedge just after the launching edge; counts cycles busy stays high.
   task automatic run_until_idle(input string tag, input int exp_cycles);
      int cyc;
      cyc = 0;
      while (busy === 1'b1 && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
      check({tag, " busy cycles"}, cyc, exp_cycles);
   endtask

   task automatic compare_product(input string tag);
      logic [2*N-1:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard: observed empty queue expected one entry", tag);
      end else begin
         e = exp_q.pop_front();
         last_exp = e;
         check({tag, " product"}, product, e);
      end
   endtask

   task automatic do_mul(input string tag, input logic [N-1:0] x, input logic [N-1:0] y);
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      push_mul(x, y);
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      check({tag, " busy after start"}, busy, 1);
      run_until_idle(tag, N);
      compare_product(tag);
   endtask

   initial begin
      #12;
      check("reset busy", busy, 0);
      check("reset product", product, 0);
      check("reset pass", pass, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_mul("3x5", 4'd3, 4'd5);
      do_mul("-8x-8", 4'h8, 4'h8);
      do_mul("-8x7", 4'h8, 4'h7);
      do_mul("7x-1", 4'h7, 4'hF);
      do_mul("0x-5", 4'h0, 4'hB);
      for (int i = 0; i < 4; i++) do_mul("random", N'($urandom), N'($urandom));

      // product holds while inputs wiggle and start stays low
      repeat (3) begin
         @(negedge clk);
         a = N'($urandom);
         b = N'($urandom);
      end
      check("product hold", product, last_exp);

      // start and test during MUL are ignored
      @(negedge clk);
      a = 4'd3;
      b = 4'd5;
      start = 1'b1;
      push_mul(4'd3, 4'd5);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'd7;
      b = 4'd7;
      start = 1'b1;
      test = 1'b1;
      @(negedge clk);
      start = 1'b0;
      test = 1'b0;
      run_until_idle("lockout", 2);
      compare_product("lockout");
      @(negedge clk);
      check("lockout no restart", busy, 0);

      // stuck-at-0 on A[0] must make BIST fail
      force dut.u_core.a_lsb = 1'b0;
      @(negedge clk);
      test = 1'b1;
      @(negedge clk);
      test = 1'b0;
      check("stuck pass cleared", pass, 0);
      run_until_idle("stuck bist", 1280);
      check("stuck pass", pass, 0);
      release dut.u_core.a_lsb;

      // test wins over start; clean BIST passes with final product -1 x -1
      @(negedge clk);
      a = 4'd1;
      b = 4'd1;
      start = 1'b1;
      test = 1'b1;
      exp_q.push_back(8'h01);
      @(negedge clk);
      start = 1'b0;
      test = 1'b0;
      check("bist busy after start", busy, 1);
      run_until_idle("bist", 1280);
      compare_product("bist");
      check("bist pass", pass, 1);

      do_mul("2x-3", 4'd2, 4'hD);
      check("pass hold", pass, 1);

      // reset mid-MUL
      @(negedge clk);
      a = 4'd7;
      b = 4'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mul reset busy", busy, 0);
      check("mul reset product", product, 0);
      check("mul reset pass", pass, 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      do_mul("2x3 after mul reset", 4'd2, 4'd3);

      // reset mid-BIST
      @(negedge clk);
      test = 1'b1;
      @(negedge clk);
      test = 1'b0;
      repeat (100) @(negedge clk);
      check("bist running", busy, 1);
      rst_n = 1'b0;
      #1;
      check("bist reset busy", busy, 0);
      check("bist reset product", product, 0);
      check("bist reset pass", pass, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_mul("2x3 after bist reset", 4'd2, 4'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter N, default 4, operand width in bits; product width is 2N.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  N  multiplicand, two's-complement signed.
REQ-005 b  input  N  multiplier, two's-complement signed.
REQ-006 start  input  1  level-sampled request for one functional multiply.
REQ-007 test  input  1  level-sampled request for a built-in self-test (BIST) run.
REQ-008 product  output  2N  registered signed result of the most recently completed multiply.
REQ-009 busy  output  1  high while a multiply or a BIST run is in progress.
REQ-010 pass  output  1  registered BIST verdict: 1 means the last BIST run had no mismatch.

Function
REQ-011 The block SHALL compute a*b as signed values with the radix-2 Booth algorithm, one Booth step per clock.
- Each step examines Q[0] and Q[-1]: 10 subtracts M from A, 01 adds M to A, 00/11 makes no change.
- Each step then arithmetic-shifts A:Q:Q[-1] right by one.
REQ-012 The state machine SHALL have the states IDLE, MUL and BIST, with BIST using a per-vector MUL sub-sequence.
REQ-013 In IDLE with busy=0, test=1 SHALL win over start=1 when both are sampled high on the same edge.
REQ-014 On an edge in IDLE with start=1 and test=0, the block SHALL latch a and b, clear A and Q[-1], set busy=1 and enter MUL.
REQ-015 MUL SHALL perform exactly N Booth steps on the next N edges.
- On the Nth edge, the block writes the 2N-bit result A:Q to product, clears busy and returns to IDLE.
- For N=4, busy is high for exactly 4 cycles.
REQ-016 While busy=1, the block SHALL ignore start, test, a and b, and SHALL not shorten or restart the operation in progress.
REQ-017 product SHALL hold its value between completions; pass SHALL hold its value except at a BIST start and a BIST end.
REQ-018 On an edge in IDLE with test=1, the block SHALL set busy=1, clear a mismatch flag and clear pass.
- It then runs all 2^(2N) operand pairs in order: an internal 2N-bit counter supplies {a_int,b_int} from 0x00 to 0xFF for N=4.
REQ-019 Each BIST vector SHALL take 1 load cycle plus N Booth cycles, giving 1280 cycles total for N=4.
- Each Booth result is written to product and compared with a combinational signed reference product of the same operands.
- Any inequality sets the mismatch flag.
REQ-020 After the last vector, the block SHALL set pass = NOT mismatch, clear busy and return to IDLE.
- For N=4 the final product is 0x01 (-1 x -1).
REQ-021 Arithmetic SHALL use N+1-bit A and M with sign extension, so that -2^(N-1) x -2^(N-1) = +2^(2N-2) without overflow (for N=4, -8 x -8 = 0x40).

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, busy=0, product=0, pass=0, and clear all datapath, counter and mismatch registers, including during MUL or BIST.
REQ-023 After rst_n is released, the first edge with start or test high SHALL begin a fresh operation as described in REQ-013 to REQ-018.

Structure
REQ-024 A shared package multiplier_pkg SHALL hold the default width constant and the state enumeration typedef.
REQ-025 The Booth datapath (A/Q/M registers, step logic) SHALL be one sub-module, booth_core, reused by the functional path and the BIST path.
- The BIST counter, reference product, comparator and FSM reside in multiplier.

Verification
REQ-026 Functional multiply: a=3, b=5, start pulsed one cycle -> busy=1 for exactly 4 cycles, then product=0x0F.
REQ-027 Signed corners:
- -8 x -8 -> 0x40.
- -8 x 7 -> 0xC8.
- 7 x -1 -> 0xF9.
- 0 x -5 -> 0x00.
REQ-028 Priority and lockout:
- start=test=1 in IDLE -> BIST runs.
- start pulsed mid-MUL -> ignored, and the result equals the first operands' product.
REQ-029 BIST: test pulsed once -> busy high for 1280 cycles, then pass=1 and product=0x01.
- With a forced stuck-at-0 on A[0] inside booth_core -> pass=0.
REQ-030 Reset mid-operation: rst_n=0 during MUL or BIST -> busy, product and pass are 0 immediately.
- A following start with 2 x 3 -> product=0x06.
